mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mcu_pkg.sv | 50 +++++
 rtl/mcu_decoder.sv | 78 +++++++
 rtl/mc_control_unit.sv | 164 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, FSM states,
// datapath mux/immediate codes and the decoded-instruction record.
package mcu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_ISH = 3'b101;

  localparam logic [1:0] RD_ALU = 2'b00;
  localparam logic [1:0] RD_MEM = 2'b01;
  localparam logic [1:0] RD_PC4 = 2'b10;
  localparam logic [1:0] RD_IMM = 2'b11;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILL
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [1:0] rdmux;
    logic       alu_a;
    logic       alu_b;
    logic [2:0] imm;
    logic [3:0] alu;
  } dec_t;

endpackage

// File: rtl/mcu_decoder.sv
// Combinational RV32I decode of opcode/func3/func7 into datapath controls
// and an instruction class consumed by the control FSM.
module mcu_decoder
  import mcu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  output dec_t       dec
);

  always_comb begin
    dec     = '0;
    dec.cls = CL_ILL;
    case (opcode)
      OP_R: begin
        dec.cls = CL_R;
        dec.alu = {func7, func3};
      end
      OP_I: begin
        dec.cls   = CL_I;
        dec.alu_b = 1'b1;
        // Only the shift-right pair uses bit 30; other immediates reuse it as data.
        if (func3 == 3'b101) begin
          dec.imm = IMM_ISH;
          dec.alu = {func7, func3};
        end else begin
          dec.imm = IMM_I;
          dec.alu = {1'b0, func3};
        end
      end
      OP_LOAD: begin
        dec.cls   = CL_LOAD;
        dec.alu_b = 1'b1;
        dec.imm   = IMM_I;
        dec.rdmux = RD_MEM;
      end
      OP_STORE: begin
        dec.cls   = CL_STORE;
        dec.alu_b = 1'b1;
        dec.imm   = IMM_S;
      end
      OP_BRANCH: begin
        dec.cls   = CL_BRANCH;
        dec.alu_a = 1'b1;
        dec.alu_b = 1'b1;
        dec.imm   = IMM_B;
      end
      OP_JAL: begin
        dec.cls   = CL_JAL;
        dec.alu_a = 1'b1;
        dec.alu_b = 1'b1;
        dec.imm   = IMM_J;
        dec.rdmux = RD_PC4;
      end
      OP_JALR: begin
        dec.cls   = CL_JALR;
        dec.alu_b = 1'b1;
        dec.imm   = IMM_I;
        dec.rdmux = RD_PC4;
      end
      OP_LUI: begin
        dec.cls   = CL_LUI;
        dec.alu_b = 1'b1;
        dec.imm   = IMM_U;
        dec.rdmux = RD_IMM;
      end
      OP_AUIPC: begin
        dec.cls   = CL_AUIPC;
        dec.alu_a = 1'b1;
        dec.alu_b = 1'b1;
        dec.imm   = IMM_U;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WB/TRAP) with ack timeout.
// Define MCU_ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module mc_control_unit
  import mcu_pkg::*;
#(
  parameter int WAIT_MAX  = 15,
  parameter int ALU_CTL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic                 func7,
  input  logic                 brnch,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dm_we,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 rd_en,
  output logic [1:0]           rdmux_sel,
  output logic                 alumux1_sel,
  output logic                 alumux2_sel,
  output logic [2:0]           imm_sel,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [2:0]           state,
  output logic                 timeout,
  output logic                 illegal
);

  // Memory handshake: a request is held high for every cycle spent in FETCH
  // or MEM; the transfer completes in the first such cycle where ack is high.
  // An ack outside a request cycle is ignored.

  state_e     state_q, state_d;
  dec_t       dec, dec_q;
  logic [7:0] cnt_q;
  logic       timeout_q;
  logic       waiting, acked, expired;

  mcu_decoder u_dec (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .dec    (dec)
  );

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign acked   = (state_q == S_FETCH) ? imem_ack : dmem_ack;
  // The WAIT_MAX-th consecutive silent cycle abandons the transfer; an ack in
  // that same cycle still wins.
  assign expired = waiting && !acked && (cnt_q == 8'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      dec_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) dec_q <= dec;
      if (!waiting || acked || expired) cnt_q <= '0;
      else                              cnt_q <= cnt_q + 8'd1;
      if (expired) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dm_we       = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    rd_en       = 1'b0;
    rdmux_sel   = '0;
    alumux1_sel = 1'b0;
    alumux2_sel = 1'b0;
    imm_sel     = '0;
    alu_ctl     = '0;
    if (!rst) begin
      // Decoded fields are only presented while an instruction is in flight.
      if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
        rdmux_sel    = dec_q.rdmux;
        alumux1_sel  = dec_q.alu_a;
        alumux2_sel  = dec_q.alu_b;
        imm_sel      = dec_q.imm;
        alu_ctl[3:0] = dec_q.alu;
      end
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          state_d = S_EXECUTE;
`ifdef MCU_ILLEGAL_TRAP_EN
          if (dec.cls == CL_ILL) state_d = S_TRAP;
`endif
        end
        S_EXECUTE: begin
          case (dec_q.cls)
            CL_LOAD, CL_STORE: state_d = S_MEM;
            CL_BRANCH: begin
              pc_load = brnch;
              pc_inc  = !brnch;
              state_d = S_FETCH;
            end
            CL_ILL: begin
              pc_inc  = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dm_we    = (dec_q.cls == CL_STORE);
          if (dmem_ack) begin
            if (dec_q.cls == CL_STORE) begin
              pc_inc  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (expired) begin
            state_d = S_FETCH;
          end
        end
        S_WB: begin
          rd_en = 1'b1;
          if (dec_q.cls == CL_JAL || dec_q.cls == CL_JALR) pc_load = 1'b1;
          else                                             pc_inc  = 1'b1;
          state_d = S_FETCH;
        end
        S_TRAP: state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state   = state_q;
  assign timeout = timeout_q;

`ifdef MCU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            illegal_q <= 1'b0;
    else if (state_q == S_DECODE && dec.cls == CL_ILL) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction cycle traces built from the
// instruction-class rules, checked every cycle, plus pinned literal values.
module tb_mc_control_unit;

  localparam int WAIT_MAX = 15;
  localparam int ALU_W    = 6;

  bit               clk;
  logic             rst;
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic             func7, brnch, imem_ack, dmem_ack;
  logic             imem_req, dmem_req, dm_we, ir_load, pc_inc, pc_load, rd_en;
  logic [1:0]       rdmux_sel;
  logic             alumux1_sel, alumux2_sel;
  logic [2:0]       imm_sel;
  logic [ALU_W-1:0] alu_ctl;
  logic [2:0]       state;
  logic             timeout, illegal;

  mc_control_unit #(.WAIT_MAX(WAIT_MAX), .ALU_CTL_W(ALU_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .brnch(brnch), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dm_we(dm_we), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .rd_en(rd_en), .rdmux_sel(rdmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .imm_sel(imm_sel),
    .alu_ctl(alu_ctl), .state(state), .timeout(timeout), .illegal(illegal)
  );

  typedef struct packed {
    logic rst; logic [6:0] op; logic [2:0] f3; logic f7, br, iack, dack;
  } stim_t;

  typedef struct packed {
    logic [2:0] st; logic ireq, dreq, we, irl, pci, pcl, rde;
    logic [1:0] rdm; logic m1, m2; logic [2:0] imm; logic [ALU_W-1:0] alu;
    logic tmo, ill;
  } obs_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  obs_t  act_log[$];
  int    n_cmp, n_fail;
  bit    m_tmo, m_ill;
  string seg;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500us");
    $fatal(1);
  end

  // scoreboard: one comparison per driven cycle
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      a = '0;
      a.st = state; a.ireq = imem_req; a.dreq = dmem_req; a.we = dm_we;
      a.irl = ir_load; a.pci = pc_inc; a.pcl = pc_load; a.rde = rd_en;
      a.rdm = rdmux_sel; a.m1 = alumux1_sel; a.m2 = alumux2_sel;
      a.imm = imm_sel; a.alu = alu_ctl; a.tmo = timeout; a.ill = illegal;
      e = exp_q.pop_front();
      act_log.push_back(a);
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h", seg, act_log.size() - 1, a, e);
      end
    end
  end

  task automatic pin(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int tally(input int from, input int sel);
    int n = 0;
    for (int i = from; i < act_log.size(); i++)
      case (sel)
        0: n += int'(act_log[i].pci);
        1: n += int'(act_log[i].pcl);
        2: n += int'(act_log[i].rde);
        3: n += int'(act_log[i].dreq);
        default: ;
      endcase
    return n;
  endfunction

  // reference model: class table and cycle-by-cycle trace per instruction
  function automatic obs_t blank();
    obs_t o = '0;
    o.tmo = m_tmo;
    o.ill = m_ill;
    return o;
  endfunction

  task automatic decode_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            output int cls, output obs_t f);
    f = '0;
    cls = 9;
    case (op)
      7'b0110011: begin cls = 0; f.alu[3:0] = {f7, f3}; end
      7'b0010011: begin
        cls = 1; f.m2 = 1'b1;
        if (f3 == 3'b101) begin f.imm = 3'd5; f.alu[3:0] = {f7, f3}; end
        else f.alu[3:0] = {1'b0, f3};
      end
      7'b0000011: begin cls = 2; f.m2 = 1'b1; f.rdm = 2'd1; end
      7'b0100011: begin cls = 3; f.m2 = 1'b1; f.imm = 3'd1; end
      7'b1100011: begin cls = 4; f.m1 = 1'b1; f.m2 = 1'b1; f.imm = 3'd2; end
      7'b1101111: begin cls = 5; f.m1 = 1'b1; f.m2 = 1'b1; f.imm = 3'd3; f.rdm = 2'd2; end
      7'b1100111: begin cls = 6; f.m2 = 1'b1; f.rdm = 2'd2; end
      7'b0110111: begin cls = 7; f.m2 = 1'b1; f.imm = 3'd4; f.rdm = 2'd3; end
      7'b0010111: begin cls = 8; f.m1 = 1'b1; f.m2 = 1'b1; f.imm = 3'd4; end
      default: ;
    endcase
  endtask

  task automatic push(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic wait_phase(input stim_t s, input obs_t f, input bit is_mem, input bit we,
                            input bit pc_on_ack, input int nwait, output bit ok);
    stim_t cs;
    obs_t  e;
    ok = 1'b0;
    for (int k = 0; k <= WAIT_MAX; k++) begin
      cs = s;
      e = '0;
      if (is_mem) begin e = f; e.st = 3'd3; e.dreq = 1'b1; e.we = we; end
      else begin e.st = 3'd0; e.ireq = 1'b1; end
      e.tmo = m_tmo;
      e.ill = m_ill;
      if (k == nwait) begin
        if (is_mem) cs.dack = 1'b1;
        else begin cs.iack = 1'b1; e.irl = 1'b1; end
        e.pci = pc_on_ack;
        push(cs, e);
        ok = 1'b1;
        return;
      end
      push(cs, e);
      if (k + 1 == WAIT_MAX) begin m_tmo = 1'b1; return; end
    end
  endtask

  task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic br, input int iwait, input int dwait, input bit rst_mem);
    stim_t s, cs;
    obs_t  f, e;
    int    cls;
    bit    ok;
    s = '0; s.op = op; s.f3 = f3; s.f7 = f7; s.br = br;
    decode_ref(op, f3, f7, cls, f);
    wait_phase(s, f, 1'b0, 1'b0, 1'b0, iwait, ok);
    if (!ok) return;
    e = blank(); e.st = 3'd1;
    push(s, e);
`ifdef MCU_ILLEGAL_TRAP_EN
    if (cls == 9) begin
      m_ill = 1'b1;
      for (int k = 0; k < 3; k++) begin
        cs = s; cs.iack = 1'b1;
        e = blank(); e.st = 3'd5;
        push(cs, e);
      end
      return;
    end
`endif
    e = f; e.tmo = m_tmo; e.ill = m_ill; e.st = 3'd2;
    if (cls == 4) begin e.pcl = br; e.pci = !br; push(s, e); return; end
    if (cls == 9) begin e.pci = 1'b1; push(s, e); return; end
    push(s, e);
    if (cls == 2 || cls == 3) begin
      if (rst_mem) begin
        cs = s; cs.rst = 1'b1;
        m_tmo = 1'b0; m_ill = 1'b0;
        e = blank();
        push(cs, e);
        return;
      end
      wait_phase(s, f, 1'b1, cls == 3, cls == 3, dwait, ok);
      if (!ok || cls == 3) return;
    end
    e = f; e.tmo = m_tmo; e.ill = m_ill; e.st = 3'd4; e.rde = 1'b1;
    if (cls == 5 || cls == 6) e.pcl = 1'b1; else e.pci = 1'b1;
    push(s, e);
  endtask

  // driver
  task automatic run();
    stim_t s;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      s = stim_q.pop_front();
      rst = s.rst; opcode = s.op; func3 = s.f3; func7 = s.f7; brnch = s.br;
      imem_ack = s.iack; dmem_ack = s.dack;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int    b;
    stim_t s;
    rst = 1'b1; opcode = '0; func3 = '0; func7 = 1'b0; brnch = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    n_cmp = 0; n_fail = 0; m_tmo = 1'b0; m_ill = 1'b0;

    seg = "reset"; b = act_log.size();
    s = '0; s.rst = 1'b1; s.iack = 1'b1;
    push(s, blank()); push(s, blank());
    run();
    pin("reset_state", int'(act_log[b].st), 0);
    pin("reset_imem_req", int'(act_log[b].ireq), 0);

    seg = "add"; b = act_log.size();
    push_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run();
    pin("add_st0", int'(act_log[b].st), 0);
    pin("add_st1", int'(act_log[b+1].st), 1);
    pin("add_st2", int'(act_log[b+2].st), 2);
    pin("add_st3", int'(act_log[b+3].st), 4);
    pin("add_rd_en_c3", int'(act_log[b+3].rde), 1);
    pin("add_alu", int'(act_log[b+2].alu), 0);
    pin("add_pc_inc_n", tally(b, 0), 1);

    seg = "lw_wait3"; b = act_log.size();
    push_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0);
    run();
    pin("lw_dmem_req_n", tally(b, 3), 4);
    pin("lw_rd_en_c7", int'(act_log[b+7].rde), 1);
    pin("lw_rd_en_n", tally(b, 2), 1);
    pin("lw_rdmux", int'(act_log[b+7].rdm), 1);

    seg = "beq_taken"; b = act_log.size();
    push_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
    run();
    pin("beq_t_len", act_log.size() - b, 3);
    pin("beq_t_pc_load", tally(b, 1), 1);
    pin("beq_t_pc_inc", tally(b, 0), 0);
    pin("beq_t_rd_en", tally(b, 2), 0);

    seg = "beq_not_taken"; b = act_log.size();
    push_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run();
    pin("beq_n_pc_inc", tally(b, 0), 1);
    pin("beq_n_pc_load", tally(b, 1), 0);
    pin("beq_n_rd_en", tally(b, 2), 0);

    seg = "sub_late_ack"; b = act_log.size();
    push_instr(7'b0110011, 3'b000, 1'b1, 1'b0, WAIT_MAX - 1, 0, 1'b0);
    run();
    pin("late_ack_ir_load", int'(act_log[b+WAIT_MAX-1].irl), 1);
    pin("late_ack_timeout", int'(act_log[act_log.size()-1].tmo), 0);
    pin("sub_alu", int'(act_log[b+WAIT_MAX+1].alu), 8);

    seg = "sw"; b = act_log.size();
    push_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
    run();
    pin("sw_len", act_log.size() - b, 4);
    pin("sw_dm_we", int'(act_log[b+3].we), 1);
    pin("sw_pc_inc", int'(act_log[b+3].pci), 1);

    seg = "jumps_imm"; b = act_log.size();
    push_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1, 0, 1'b0);
    push_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    push_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    push_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run();
    pin("jal_pc_load", int'(act_log[b+4].pcl), 1);
    pin("jal_rdmux", int'(act_log[b+4].rdm), 2);
    pin("jumps_pc_pulses", tally(b, 0) + tally(b, 1), 4);

    seg = "i_alu"; b = act_log.size();
    push_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, 1'b0);
    push_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
    push_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
    run();
    pin("srai_alu", int'(act_log[b+2].alu), 13);
    pin("srai_imm", int'(act_log[b+2].imm), 5);
    pin("addi_f7_forced", int'(act_log[b+6].alu), 0);

    seg = "fetch_timeout"; b = act_log.size();
    push_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1000, 0, 1'b0);
    push_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run();
    pin("tmo_before", int'(act_log[b+WAIT_MAX-1].tmo), 0);
    pin("tmo_after", int'(act_log[b+WAIT_MAX].tmo), 1);
    pin("tmo_state", int'(act_log[b+WAIT_MAX].st), 0);
    pin("tmo_pc_pulses", tally(b, 0) + tally(b, 1), 1);

    seg = "sw_reset_in_mem"; b = act_log.size();
    push_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b1);
    run();
    pin("rst_mem_dm_we", int'(act_log[b+3].we), 0);
    pin("rst_mem_state", int'(act_log[b+3].st), 0);
    pin("rst_mem_pc_pulses", tally(b, 0) + tally(b, 1), 0);
    seg = "after_reset"; b = act_log.size();
    push_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);
    run();
    pin("post_rst_imem_req", int'(act_log[b].ireq), 1);
    pin("post_rst_timeout", int'(act_log[b].tmo), 0);

    seg = "illegal"; b = act_log.size();
    push_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
`ifndef MCU_ILLEGAL_TRAP_EN
    push_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
`endif
    run();
`ifdef MCU_ILLEGAL_TRAP_EN
    pin("ill_state", int'(act_log[b+2].st), 5);
    pin("ill_flag", int'(act_log[b+2].ill), 1);
    pin("ill_pc_pulses", tally(b, 0) + tally(b, 1), 0);
`else
    pin("nop_pc_inc", int'(act_log[b+2].pci), 1);
    pin("nop_refetch", int'(act_log[b+3].st), 0);
    pin("nop_flag", int'(act_log[b+2].ill), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
